pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/hazard_detect.sv | 30 +++
 rtl/pipe_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: FSM state encoding, opcodes, stage-control bundle.
// Used by pipe_ctrl and hazard_detect.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    MWAIT = 2'd2,
    FLUSH = 2'd3
  } st_t;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_NOP = 6'b000000;

  typedef struct packed {
    logic stall;
    logic flush;
    logic bubble;
  } stage_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use and memory-access detection for the pipeline controller.
// Purely combinational; the x0 destination never creates a dependency.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter logic [5:0] LW_OP = OP_LW,
  parameter logic [5:0] SW_OP = OP_SW
) (
  input  logic [5:0] op_ex,
  input  logic [4:0] Ri_ex,
  input  logic [4:0] Rs_id,
  input  logic [4:0] Rt_id,
  input  logic [5:0] op_mem,
  output logic       mem_access,
  output logic       ld_use
);

  logic src_hit;

  assign mem_access = (op_mem == LW_OP) ||
                      (op_mem == SW_OP);

  assign src_hit = (Ri_ex == Rs_id) ||
                   (Ri_ex == Rt_id);

  assign ld_use = (op_ex == LW_OP) &&
                  (Ri_ex != 5'd0) &&
                  src_hit;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory wait/timeout.
// Define PIPE_CTRL_PERF_EN to add the saturating stall_cnt output.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter logic [5:0]  LW_OP    = OP_LW,
  parameter logic [5:0]  SW_OP    = OP_SW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op_id,
  input  logic [4:0]  Rs_id,
  input  logic [4:0]  Rt_id,
  input  logic [5:0]  op_ex,
  input  logic [4:0]  Ri_ex,
  input  logic        br_taken_ex,
  input  logic [5:0]  op_mem,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic        stall_mem,
  output logic        mem_timeout,
  output logic [1:0]  state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  st_t         st;
  st_t         st_free;
  logic [7:0]  wait_cnt;
  logic        mem_access;
  logic        ld_use;
  logic        mem_wait;
  logic        timeout;
  logic        live;
  logic        hold;
  logic        free;
  stage_ctrl_t if_c;
  stage_ctrl_t id_c;
  stage_ctrl_t ex_c;
  stage_ctrl_t mem_c;
  logic        unused_ctl;

  hazard_detect #(
    .LW_OP (LW_OP),
    .SW_OP (SW_OP)
  ) u_hazard (
    .op_ex      (op_ex),
    .Ri_ex      (Ri_ex),
    .Rs_id      (Rs_id),
    .Rt_id      (Rt_id),
    .op_mem     (op_mem),
    .mem_access (mem_access),
    .ld_use     (ld_use)
  );

  assign mem_wait = mem_access & ~mem_ready;
  assign live     = (st == RUN) || (st == MWAIT);

  // Timeout fires in the cycle the counter reaches WAIT_MAX.
  assign timeout  = (st == MWAIT) & mem_wait &
                    (wait_cnt == 8'(WAIT_MAX - 1));

  assign hold = live & mem_wait & ~timeout;

  // A releasing wait re-presents EX, so it decodes like RUN.
  assign free = live & ~hold;

  always_comb begin
    st_free = RUN;
    if (br_taken_ex) st_free = FLUSH;
    else if (ld_use) st_free = LDUSE;
  end

  always_comb begin
    if_c  = '0;
    id_c  = '0;
    ex_c  = '0;
    mem_c = '0;
    unique case (1'b1)
      hold: begin
        if_c.stall  = 1'b1;
        id_c.stall  = 1'b1;
        mem_c.stall = 1'b1;
      end
      free && br_taken_ex: begin
        id_c.flush  = 1'b1;
        ex_c.bubble = 1'b1;
      end
      free && !br_taken_ex && ld_use: begin
        if_c.stall  = 1'b1;
        id_c.stall  = 1'b1;
        ex_c.bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_if    = if_c.stall;
  assign stall_id    = id_c.stall;
  assign flush_id    = id_c.flush;
  assign bubble_ex   = ex_c.bubble;
  assign stall_mem   = mem_c.stall;
  assign mem_timeout = timeout;
  assign state       = st;

  assign unused_ctl = ^{if_c.flush, if_c.bubble,
                        id_c.bubble, ex_c.stall,
                        ex_c.flush, mem_c.flush,
                        mem_c.bubble, op_id};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      unique case (st)
        RUN: begin
          if (hold) begin
            st       <= MWAIT;
            wait_cnt <= 8'd0;
          end else begin
            st <= st_free;
          end
        end
        MWAIT: begin
          if (mem_wait) wait_cnt <= wait_cnt + 8'd1;
          if (!hold) st <= st_free;
        end
        default: st <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (stall_if && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl with WAIT_MAX=4.
// Builds with or without PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] NO = 6'b000000;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_LDU = 2'd1;
  localparam logic [1:0] S_MW  = 2'd2;
  localparam logic [1:0] S_FL  = 2'd3;

  // {stall_if, stall_id, bubble_ex, flush_id, stall_mem, mem_timeout}
  localparam logic [5:0] E_0  = 6'b000000;
  localparam logic [5:0] E_LD = 6'b111000;
  localparam logic [5:0] E_BR = 6'b001100;
  localparam logic [5:0] E_MW = 6'b110010;
  localparam logic [5:0] E_TO = 6'b000001;

  logic        clk;
  logic        rst_n;
  logic [5:0]  op_id;
  logic [4:0]  Rs_id;
  logic [4:0]  Rt_id;
  logic [5:0]  op_ex;
  logic [4:0]  Ri_ex;
  logic        br_taken_ex;
  logic [5:0]  op_mem;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_id;
  logic        bubble_ex;
  logic        flush_id;
  logic        stall_mem;
  logic        mem_timeout;
  logic [1:0]  state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int checks;
  int failures;
  int exp_stalls;
  logic [7:0] sb[$];

  pipe_ctrl #(
    .WAIT_MAX (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_id       (op_id),
    .Rs_id       (Rs_id),
    .Rt_id       (Rt_id),
    .op_ex       (op_ex),
    .Ri_ex       (Ri_ex),
    .br_taken_ex (br_taken_ex),
    .op_mem      (op_mem),
    .mem_ready   (mem_ready),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .bubble_ex   (bubble_ex),
    .flush_id    (flush_id),
    .stall_mem   (stall_mem),
    .mem_timeout (mem_timeout),
    .state       (state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {24'd0, state, stall_if, stall_id,
            bubble_ex, flush_id, stall_mem,
            mem_timeout};
  endfunction

  task automatic step(input string      tag,
                      input logic [5:0] oex,
                      input logic [4:0] rex,
                      input logic [4:0] rs,
                      input logic [4:0] rt,
                      input logic       br,
                      input logic [5:0] omem,
                      input logic       rdy,
                      input logic [1:0] est,
                      input logic [5:0] eo);
    logic [7:0] e;
    @(negedge clk);
    op_id       = 6'($urandom);
    op_ex       = oex;
    Ri_ex       = rex;
    Rs_id       = rs;
    Rt_id       = rt;
    br_taken_ex = br;
    op_mem      = omem;
    mem_ready   = rdy;
    sb.push_back({est, eo});
    if (eo[5]) exp_stalls++;
    #2;
    e = sb.pop_front();
    check(tag, obs(), {24'd0, e});
  endtask

  task automatic idle(input string tag, input logic [1:0] est);
    step(tag, NO, 5'd0, 5'd0, 5'd0, 1'b0, NO, 1'b1, est, E_0);
  endtask

  task automatic tmo_seq(input string tag);
    step({tag, "_c1"}, NO, 0, 0, 0, 0, LW, 0, S_RUN, E_MW);
    step({tag, "_c2"}, NO, 0, 0, 0, 0, LW, 0, S_MW, E_MW);
    step({tag, "_c3"}, NO, 0, 0, 0, 0, LW, 0, S_MW, E_MW);
    step({tag, "_c4"}, NO, 0, 0, 0, 0, LW, 0, S_MW, E_MW);
    step({tag, "_c5"}, NO, 0, 0, 0, 0, LW, 0, S_MW, E_TO);
    idle({tag, "_run"}, S_RUN);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_stalls  = 0;
    rst_n       = 1'b0;
    op_id       = NO;
    Rs_id       = 5'd0;
    Rt_id       = 5'd0;
    op_ex       = NO;
    Ri_ex       = 5'd0;
    br_taken_ex = 1'b0;
    op_mem      = NO;
    mem_ready   = 1'b1;
    #3;
    check("reset", obs(), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    check("reset_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    step("lu_rs", LW, 5, 5, 0, 0, NO, 1, S_RUN, E_LD);
    step("lu_hold", NO, 0, 5, 0, 0, LW, 1, S_LDU, E_0);
    idle("lu_done", S_RUN);
    step("lu_rt", LW, 7, 3, 7, 0, NO, 1, S_RUN, E_LD);
    step("lu_rt_hold", NO, 0, 3, 7, 0, LW, 1, S_LDU, E_0);
    step("sw_no_lu", SW, 5, 5, 0, 0, NO, 1, S_RUN, E_0);
    step("lw_nomatch", LW, 5, 6, 4, 0, NO, 1, S_RUN, E_0);
    step("lu_r0", LW, 0, 0, 0, 0, NO, 1, S_RUN, E_0);
    idle("lu_r0_after", S_RUN);

    step("br", NO, 0, 0, 0, 1, NO, 1, S_RUN, E_BR);
    idle("br_flush", S_FL);
    idle("br_run", S_RUN);
    step("br_over_lu", LW, 9, 9, 0, 1, NO, 1, S_RUN, E_BR);
    idle("br_lu_flush", S_FL);
    idle("br_lu_run", S_RUN);

`ifdef PIPE_CTRL_PERF_EN
    @(posedge clk);
    #1;
    check("perf_cnt", stall_cnt, 32'(exp_stalls));
`endif

    step("sw_c1", NO, 0, 0, 0, 1, SW, 0, S_RUN, E_MW);
    step("sw_c2", NO, 0, 0, 0, 1, SW, 0, S_MW, E_MW);
    step("sw_c3", NO, 0, 0, 0, 1, SW, 0, S_MW, E_MW);
    step("sw_rel", NO, 0, 0, 0, 0, SW, 1, S_MW, E_0);
    idle("sw_run", S_RUN);

    tmo_seq("tmo_a");
    tmo_seq("tmo_b");

    step("rst_c1", NO, 0, 0, 0, 0, LW, 0, S_RUN, E_MW);
    step("rst_c2", NO, 0, 0, 0, 0, LW, 0, S_MW, E_MW);
    step("rst_c3", NO, 0, 0, 0, 0, LW, 0, S_MW, E_MW);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async", obs(), {24'd0, S_RUN, E_MW});
    @(negedge clk);
    op_mem    = NO;
    mem_ready = 1'b1;
    #1;
    check("rst_held", obs(), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    check("rst_cnt", stall_cnt, 32'd0);
`endif
    rst_n      = 1'b1;
    exp_stalls = 0;

    tmo_seq("tmo_post");

`ifdef PIPE_CTRL_PERF_EN
    @(posedge clk);
    #1;
    check("perf_post", stall_cnt, 32'(exp_stalls));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
